bus_arbiter_4x16: RTL and testbench

BUS_ARBITER_4X16 -- requirements
Module: bus_arbiter_4x16

---
 rtl/bus_arbiter_4x16.sv | 114 +++++++++++
 tb/tb_bus_arbiter_4x16.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_4x16.sv
// rtl/bus_arbiter_4x16.sv - four-requester round-robin bus arbiter with hold limit and 16-bit data mux
// Owner keeps the bus until it drops req or reaches MAX_HOLD cycles; handoff happens without an idle cycle.
module bus_arbiter_4x16 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  input  logic [15:0] data3,
  output logic [3:0]  gnt,
  output logic [1:0]  sel,
  output logic        busy,
  output logic [15:0] out_data,
  output logic        out_valid
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t      state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [1:0]  sel_q, sel_d;
  logic [1:0]  last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;

  logic [15:0] owner_data;
  logic        owner_req;
  logic        hold_max;
  logic [1:0]  winner;

  // Scan from last+4 down to last+1 so the lowest offset (highest priority) wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    owner_data = data0;
    case (sel_q)
      2'd0: owner_data = data0;
      2'd1: owner_data = data1;
      2'd2: owner_data = data2;
      2'd3: owner_data = data3;
      default: owner_data = data0;
    endcase
  end

  assign owner_req = req[sel_q];
  assign hold_max  = (cnt_q == HOLD_LAST);
  assign winner    = rr_pick(req, last_q);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = (state_q == OWN) && owner_req;
    if (out_valid_d) out_data_d = owner_data;

    if (state_q == IDLE || !owner_req || hold_max) begin
      if (|req) begin
        state_d = OWN;
        gnt_d   = 4'b0001 << winner;
        sel_d   = winner;
        last_d  = winner;
        cnt_d   = 8'd0;
      end else begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= 4'b0000;
      sel_q       <= 2'd0;
      last_q      <= 2'd3;
      cnt_q       <= 8'd0;
      out_data_q  <= 16'h0000;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign busy      = (state_q == OWN);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bus_arbiter_4x16.sv
// tb/tb_bus_arbiter_4x16.sv - scoreboard bench for bus_arbiter_4x16
// Stimulus queues expected per-edge results; the monitor pops and compares on the falling edge.
module tb_bus_arbiter_4x16;

  localparam logic [15:0] D0 = 16'h1111;
  localparam logic [15:0] D1 = 16'h2222;
  localparam logic [15:0] D2 = 16'hBEEF;
  localparam logic [15:0] D3 = 16'h4444;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [15:0] data0 = D0;
  logic [15:0] data1 = D1;
  logic [15:0] data2 = D2;
  logic [15:0] data3 = D3;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic        busy;
  logic [15:0] out_data;
  logic        out_valid;

  typedef struct {
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        busy;
    logic        valid;
    logic [15:0] data;
  } exp_t;

  exp_t        ctrl_q[$];
  logic [15:0] data_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          done = 1'b0;

  bus_arbiter_4x16 #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data0     (data0),
    .data1     (data1),
    .data2     (data2),
    .data3     (data3),
    .gnt       (gnt),
    .sel       (sel),
    .busy      (busy),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] dw(input int i);
    case (i)
      0: dw = D0;
      1: dw = D1;
      2: dw = D2;
      default: dw = D3;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Apply req for one edge and queue what the outputs must be after that edge.
  task automatic step(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s,
                      input logic b, input logic v, input logic [15:0] d);
    exp_t e;
    req = r;
    @(posedge clk);
    #1;
    e.gnt = g; e.sel = s; e.busy = b; e.valid = v; e.data = d;
    ctrl_q.push_back(e);
    if (v) data_q.push_back(d);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        chk("rst_gnt", 16'(gnt), 16'h0);
        chk("rst_sel", 16'(sel), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_out_data", out_data, 16'h0);
        chk("rst_out_valid", 16'(out_valid), 16'h0);
      end else begin
        chk("gnt_onehot0", 16'($onehot0(gnt)), 16'h1);
        if (ctrl_q.size() > 0) begin
          e = ctrl_q.pop_front();
          chk("gnt", 16'(gnt), 16'(e.gnt));
          chk("sel", 16'(sel), 16'(e.sel));
          chk("busy", 16'(busy), 16'(e.busy));
          chk("out_valid", 16'(out_valid), 16'(e.valid));
          if (!e.valid) chk("out_data_hold", out_data, e.data);
        end
        if (out_valid) begin
          if (data_q.size() == 0) chk("unexpected_valid", 16'h1, 16'h0);
          else chk("out_data", out_data, data_q.pop_front());
        end
        if (done) begin
          chk("ctrl_drained", 16'(ctrl_q.size()), 16'h0);
          chk("data_drained", 16'(data_q.size()), 16'h0);
          $display("Result: errors=%0d of %0d checks", errors, checks);
          $finish;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : stimulus
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // first arbitration after reset, then drop all
    step(4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0, 16'h0000);
    step(4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1, D1);
    step(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, D1);
    step(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, D1);

    // owner 2 drops while 3 rises: same-edge handoff
    step(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, D1);
    step(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, D2);
    step(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, D2);
    step(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1, D3);
    step(4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, D3);

    // all requesting: 8-cycle turns 0,1,2,3,0 with no gap
    for (int k = 0; k < 34; k++) begin
      int o;
      o = (k / 8) % 4;
      step(4'b1111, 4'(1 << o), 2'(o), 1'b1, k > 0, (k > 0) ? dw(((k - 1) / 8) % 4) : D3);
    end
    step(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, D0);

    // lone requester re-granted at preemption; later rival waits for the hold limit
    for (int k = 0; k < 20; k++) step(4'b0001, 4'b0001, 2'd0, 1'b1, k > 0, D0);
    for (int k = 20; k < 24; k++) step(4'b0011, 4'b0001, 2'd0, 1'b1, 1'b1, D0);
    step(4'b0011, 4'b0010, 2'd1, 1'b1, 1'b1, D0);
    step(4'b0011, 4'b0010, 2'd1, 1'b1, 1'b1, D1);
    step(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, D1);

    // asynchronous reset mid-grant, then re-arbitrate
    step(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, D1);
    step(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, D2);
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 16'h0000);
    step(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, D2);
    step(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, D2);

    // round-robin pointer after owner 2: 3 beats 0 and 1, then wrap to 0
    step(4'b1011, 4'b1000, 2'd3, 1'b1, 1'b0, D2);
    step(4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0, D2);
    step(4'b0011, 4'b0001, 2'd0, 1'b1, 1'b1, D0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, D0);

    done = 1'b1;
  end

endmodule
